// File: rtl/game_pkg.sv
// Shared constants for the slot game: reel geometry, LFSR setup and the symbol
// codes used by the game FSM and the display driver.
package game_pkg;

  localparam int SYMBOL_W   = 4;
  localparam int REEL_COUNT = 4;
  localparam int STEP_W     = 3;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Codes above the reel symbol range, reserved for messages on the display.
  localparam logic [SYMBOL_W-1:0] CODE_WIN   = 4'hC;
  localparam logic [SYMBOL_W-1:0] CODE_LOSE  = 4'hD;
  localparam logic [SYMBOL_W-1:0] CODE_DASH  = 4'hE;
  localparam logic [SYMBOL_W-1:0] CODE_BLANK = 4'hF;

  // Modulo add on a reel: the sum is one bit wider so letter+step never overflows.
  function automatic logic [SYMBOL_W-1:0] wrap_add(input logic [SYMBOL_W-1:0] letter,
                                                   input logic [STEP_W-1:0]   step,
                                                   input int                  symbols);
    logic [SYMBOL_W:0] sum;
    logic [SYMBOL_W:0] limit;
    limit = symbols[SYMBOL_W:0];
    sum   = {1'b0, letter} + {2'b00, step};
    if (sum >= limit) sum = sum - limit;
    return sum[SYMBOL_W-1:0];
  endfunction

endpackage

// File: rtl/reel_counter.sv
// One reel: a 0..IDX sub-counter sets the stepping rate, the letter register
// wraps modulo SYMBOLS.
import game_pkg::*;

module reel_counter #(
  parameter int IDX     = 0,
  parameter int SYMBOLS = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                run,
  input  logic [STEP_W-1:0]   step,
  output logic [SYMBOL_W-1:0] letter
);

  localparam logic [1:0]          LAST  = 2'(IDX);
  localparam logic [SYMBOL_W-1:0] START = SYMBOL_W'(IDX);

  logic [1:0] sub;
  logic       advance;

  assign advance = tick & run & (sub == LAST);

  // NOTE: non-blocking assignments keep sub and letter both reading pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sub    <= '0;
      letter <= START;
    end else if (tick) begin
      // A held reel restarts a full period when it resumes.
      if (run) sub <= (sub == LAST) ? 2'd0 : sub + 2'd1;
      else     sub <= 2'd0;
      if (advance) letter <= wrap_add(letter, step, SYMBOLS);
    end
  end

endmodule

// File: rtl/reel_spinner.sv
// Four-reel spinner: free-running tick prescaler feeding staggered reel counters.
// Define REEL_LFSR_EN to replace the unit step with a pseudo-random 1..4 step.
import game_pkg::*;

module reel_spinner #(
  parameter int TICK_DIV = 2_500_000,
  parameter int SYMBOLS  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          run,
  output logic [SYMBOL_W-1:0] letter0,
  output logic [SYMBOL_W-1:0] letter1,
  output logic [SYMBOL_W-1:0] letter2,
  output logic [SYMBOL_W-1:0] letter3,
  output logic                all_stopped
);

  localparam int               CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0]    cnt;
  logic                tick;
  logic [STEP_W-1:0]   step;
  logic [SYMBOL_W-1:0] letters [REEL_COUNT];

  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

`ifdef REEL_LFSR_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
  end

  assign step = 3'd1 + {1'b0, lfsr[1:0]};
`else
  assign step = 3'd1;
`endif

  for (genvar i = 0; i < REEL_COUNT; i++) begin : g_reel
    reel_counter #(
      .IDX     (i),
      .SYMBOLS (SYMBOLS)
    ) u_reel (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .run    (run[i]),
      .step   (step),
      .letter (letters[i])
    );
  end

  assign letter0 = letters[0];
  assign letter1 = letters[1];
  assign letter2 = letters[2];
  assign letter3 = letters[3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) all_stopped <= 1'b0;
    else       all_stopped <= (run == 4'h0);
  end

endmodule

// File: tb/tb_reel_spinner.sv
// Directed bench for reel_spinner with TICK_DIV=4, SYMBOLS=10; with REEL_LFSR_EN
// it instead checks the random step distribution and the letter range.
module tb_reel_spinner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] run;
  logic [3:0] letter0, letter1, letter2, letter3;
  logic       all_stopped;

  int checks    = 0;
  int errors    = 0;
  int range_bad = 0;

  reel_spinner #(
    .TICK_DIV (4),
    .SYMBOLS  (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .letter0     (letter0),
    .letter1     (letter1),
    .letter2     (letter2),
    .letter3     (letter3),
    .all_stopped (all_stopped)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && (letter0 >= 10 || letter1 >= 10 || letter2 >= 10 || letter3 >= 10))
      range_bad++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input int e0, input int e1, input int e2,
                           input int e3, input logic es);
    check({name, " letter0"}, 32'(letter0), e0);
    check({name, " letter1"}, 32'(letter1), e1);
    check({name, " letter2"}, 32'(letter2), e2);
    check({name, " letter3"}, 32'(letter3), e3);
    check({name, " all_stopped"}, 32'(all_stopped), 32'(es));
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    string      name;
    logic [3:0] run;
    int         cycles;
    int         l0, l1, l2, l3;
    logic       stop;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{"first tick",   4'hF,  4, 1, 1, 2, 3, 1'b0};
    vecs[1] = '{"12 ticks",     4'hF, 44, 2, 7, 6, 6, 1'b0};
    vecs[2] = '{"all held",     4'h0,  4, 2, 7, 6, 6, 1'b1};
    vecs[3] = '{"reel0 to 9",   4'h1, 28, 9, 7, 6, 6, 1'b0};
    vecs[4] = '{"reel0 wrap",   4'h1,  4, 0, 7, 6, 6, 1'b0};
    vecs[5] = '{"resume 2t",    4'hF,  8, 2, 8, 6, 6, 1'b0};
    vecs[6] = '{"resume 3t",    4'hF,  4, 3, 8, 7, 6, 1'b0};
    vecs[7] = '{"reel3 only",   4'h8,  4, 3, 8, 7, 7, 1'b0};

    reset = 1'b1;
    run   = 4'hF;
    clocks(2);
    check_all("reset", 0, 1, 2, 3, 1'b0);
    reset = 1'b0;

`ifdef REEL_LFSR_EN
    begin
      int prev;
      int delta;
      int step_bad = 0;
      bit seen [5] = '{default: 1'b0};
      prev = int'(letter0);
      for (int t = 0; t < 1000; t++) begin
        clocks(4);
        delta = (int'(letter0) + 10 - prev) % 10;
        if (delta >= 1 && delta <= 4) seen[delta] = 1'b1;
        else step_bad++;
        prev = int'(letter0);
      end
      check("lfsr step range", 32'(step_bad), 0);
      for (int s = 1; s <= 4; s++) check($sformatf("lfsr step %0d seen", s), 32'(seen[s]), 1);
    end
`else
    // Reel 0 steps at edge 4, reel 1 at edge 8.
    clocks(3);
    check("edge3 letter0", 32'(letter0), 0);
    clocks(1);
    check("edge4 letter0", 32'(letter0), 1);
    check("edge4 letter1", 32'(letter1), 1);
    clocks(4);
    check("edge8 letter1", 32'(letter1), 2);
    check("edge8 letter0", 32'(letter0), 2);

    // Reset mid-spin must take effect before the next clock edge.
    clocks(2);
    reset = 1'b1;
    #1;
    check_all("async reset", 0, 1, 2, 3, 1'b0);
    clocks(1);
    reset = 1'b0;

    foreach (vecs[k]) begin
      run = vecs[k].run;
      clocks(vecs[k].cycles);
      check_all(vecs[k].name, vecs[k].l0, vecs[k].l1, vecs[k].l2, vecs[k].l3, vecs[k].stop);
    end

    // Drop run[0] during the tick cycle; reel 0 must freeze for 100 clk.
    begin
      int hold_bad = 0;
      run = 4'hF;
      clocks(3);
      run = 4'hE;
      clocks(1);
      check("race letter0", 32'(letter0), 3);
      for (int c = 0; c < 100; c++) begin
        clocks(1);
        if (letter0 !== 4'd3) hold_bad++;
      end
      check("race hold count", 32'(hold_bad), 0);
      check_all("after race", 3, 1, 5, 3, 1'b0);
    end

    // Stop reels in order, then restart all.
    run = 4'hC;
    clocks(1);
    run = 4'h8;
    clocks(1);
    check("stop partial", 32'(all_stopped), 0);
    run = 4'h0;
    clocks(1);
    check("stop one clk", 32'(all_stopped), 1);
    clocks(1);
    check_all("stopped", 3, 1, 5, 3, 1'b1);
    run = 4'hF;
    clocks(1);
    check("restart clears", 32'(all_stopped), 0);
    clocks(3);
    check("restart t1 letter0", 32'(letter0), 4);
    check("restart t1 letter1", 32'(letter1), 1);
    clocks(4);
    check("restart t2 letter0", 32'(letter0), 5);
    check("restart t2 letter1", 32'(letter1), 2);
`endif

    check("letter range", 32'(range_bad), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
